// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the single-port RAM controller.
//   state_t         : controller state (CLEAR fills memory, IDLE serves accesses)
//   even_parity()   : even-parity bit over the low 'width' bits of a word
//   read_latency_ok : legality check for the READ_LATENCY parameter
package ram_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam int unsigned PARITY_MAX_W = 64;
    localparam int unsigned RD_LAT_MIN   = 1;
    localparam int unsigned RD_LAT_MAX   = 2;

    function automatic logic read_latency_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    // Bits above 'width' are ignored, so narrower words can be passed zero-extended.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v,
                                         input int unsigned             width);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < PARITY_MAX_W; i++) begin
            if (i < width) p = p ^ v[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// ram_read_pipe: DEPTH-stage data/valid delay line for the RAM read path.
// Each stage only captures data when its incoming valid is set, so the last
// stage (data_o) holds the most recent read between reads. rst flushes all
// stages synchronously.
//   clk, rst  : clock, synchronous active-high reset
//   valid_i   : a read was accepted this cycle
//   data_i    : word read from the array
//   valid_o   : one-cycle pulse DEPTH cycles after valid_i
//   data_o    : delayed read data (held between reads)
module ram_read_pipe #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) data_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: single-port synchronous RAM with registered read path,
// read-valid strobe, 1- or 2-cycle read latency and a post-reset clear
// sequencer that fills the array with INIT_VALUE.
// Optional feature macro: RAM_SP_CTRL_PARITY_EN (stores an even-parity bit per
// word, adds inject_err input and parity_err output).
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   write      : store data at address
//   load       : start a read of address
//   address    : shared access address
//   data       : write data
//   inject_err : (parity build) invert stored parity bit on this write
//   data_out   : read data, held between reads
//   data_valid : one-cycle pulse when data_out is new
//   parity_err : (parity build) pulse with data_valid on parity mismatch
//   busy       : clear sequence running, accesses are dropped
//
// state | meaning
// CLEAR | writing INIT_VALUE to clear_addr, one word per cycle; busy=1
// IDLE  | serving write/load requests
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH     = 20,
    parameter int unsigned          ADDR_WIDTH     = 10,
    parameter int unsigned          RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int unsigned          READ_LATENCY   = 1,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
`ifdef RAM_SP_CTRL_PARITY_EN
    input  logic                  inject_err,
    output logic                  parity_err,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy
);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
        $error("ram_sp_ctrl: READ_LATENCY must be 1 or 2");
    end

`ifdef RAM_SP_CTRL_PARITY_EN
    localparam int unsigned MEM_W = DATA_WIDTH + 1;
    localparam logic [MEM_W-1:0] CLEAR_WORD =
        {even_parity(PARITY_MAX_W'(INIT_VALUE), DATA_WIDTH), INIT_VALUE};
`else
    localparam int unsigned MEM_W = DATA_WIDTH;
    localparam logic [MEM_W-1:0] CLEAR_WORD = INIT_VALUE;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic [MEM_W-1:0]      mem [RAM_DEPTH];

    logic                  in_range;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      data_word;
    logic [MEM_W-1:0]      rd_word;
    logic [MEM_W-1:0]      pipe_in;
    logic [MEM_W-1:0]      pipe_out;
    logic                  rd_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        busy         = 1'b0;
        case (state_q)
            CLEAR: begin
                busy         = 1'b1;
                clear_addr_d = clear_addr_q + 1'b1;
                if (clear_addr_q == LAST_ADDR) begin
                    state_d      = IDLE;
                    clear_addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign in_range = 32'(address) < RAM_DEPTH;

`ifdef RAM_SP_CTRL_PARITY_EN
    assign data_word = {even_parity(PARITY_MAX_W'(data), DATA_WIDTH) ^ inject_err, data};
`else
    assign data_word = data;
`endif

    // Writes are gated by rst so that a reset never disturbs memory contents.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_word = data_word;
        if (!rst) begin
            if (state_q == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = clear_addr_q;
                wr_word = CLEAR_WORD;
            end else if (write && in_range) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_word;
    end

    // The array is read before the same-edge write lands, giving read-first.
    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = mem[address];
    end

    assign rd_accept = load && (state_q == IDLE);

`ifdef RAM_SP_CTRL_PARITY_EN
    // The mismatch flag travels down the pipe alongside the data word.
    logic rd_perr;
    assign rd_perr  = in_range &&
        (even_parity(PARITY_MAX_W'(rd_word[DATA_WIDTH-1:0]), DATA_WIDTH) != rd_word[DATA_WIDTH]);
    assign pipe_in  = {rd_perr, rd_word[DATA_WIDTH-1:0]};
    assign data_out = pipe_out[DATA_WIDTH-1:0];
    assign parity_err = pipe_out[DATA_WIDTH] & data_valid;
`else
    assign pipe_in  = rd_word;
    assign data_out = pipe_out;
`endif

    ram_read_pipe #(
        .WIDTH (MEM_W),
        .DEPTH (READ_LATENCY)
    ) u_read_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_accept),
        .data_i  (pipe_in),
        .valid_o (data_valid),
        .data_o  (pipe_out)
    );

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// tb_ram_sp_ctrl: directed bench for ram_sp_ctrl. Three instances share one
// stimulus: d1 (16 words, latency 1), d2 (16 words, latency 2) and
// d3 (12 words, latency 1) to cover the out-of-range address behaviour.
module tb_ram_sp_ctrl;

    localparam int DW = 20;
    localparam int AW = 4;
    localparam logic [DW-1:0] INIT = 20'hABCDE;

    logic          clk = 1'b0;
    logic          rst, write, load;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic [DW-1:0] q1, q2, q3;
    logic          v1, v2, v3, b1, b2, b3;
`ifdef RAM_SP_CTRL_PARITY_EN
    logic          inject_err;
    logic          pe1, pe2, pe3;
`endif

    int tests = 0;
    int fails = 0;
    int n1, n2, n3, nv;

    always #5 clk = ~clk;

    ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(16), .READ_LATENCY(1),
                  .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)) dut1 (
        .clk(clk), .rst(rst), .write(write), .load(load), .address(address), .data(data),
`ifdef RAM_SP_CTRL_PARITY_EN
        .inject_err(inject_err), .parity_err(pe1),
`endif
        .data_out(q1), .data_valid(v1), .busy(b1));

    ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(16), .READ_LATENCY(2),
                  .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)) dut2 (
        .clk(clk), .rst(rst), .write(write), .load(load), .address(address), .data(data),
`ifdef RAM_SP_CTRL_PARITY_EN
        .inject_err(inject_err), .parity_err(pe2),
`endif
        .data_out(q2), .data_valid(v2), .busy(b2));

    ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(12), .READ_LATENCY(1),
                  .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)) dut3 (
        .clk(clk), .rst(rst), .write(write), .load(load), .address(address), .data(data),
`ifdef RAM_SP_CTRL_PARITY_EN
        .inject_err(inject_err), .parity_err(pe3),
`endif
        .data_out(q3), .data_valid(v3), .busy(b3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_w;

        rst = 1'b1; write = 1'b0; load = 1'b0; address = '0; data = '0;
`ifdef RAM_SP_CTRL_PARITY_EN
        inject_err = 1'b0;
`endif
        step; step;
        check("rst_q1", {v1, q1}, 32'h0);
        check("rst_q2", {v2, q2}, 32'h0);
        check("rst_busy1", b1, 1);
        check("rst_busy3", b3, 1);

        // clear duration after reset release
        rst = 1'b0;
        n1 = 0; n2 = 0; n3 = 0;
        for (int c = 0; c < 40; c++) begin
            n1 += int'(b1); n2 += int'(b2); n3 += int'(b3);
            step;
        end
        check("clear_cycles1", n1, 16);
        check("clear_cycles2", n2, 16);
        check("clear_cycles3", n3, 12);

        // back-to-back readback of the cleared array
        for (int i = 0; i < 16; i++) begin
            load = 1'b1; address = AW'(i);
            step;
            check("clr_rd1", {v1, q1}, {1'b1, INIT});
            check("clr_rd3", {v3, q3}, {1'b1, (i < 12) ? INIT : 20'h0});
            if (i > 0) check("clr_rd2", {v2, q2}, {1'b1, INIT});
            else       check("clr_rd2_lat", v2, 0);
        end
        load = 1'b0;
        step;
        check("clr_rd2_last", {v2, q2}, {1'b1, INIT});
        check("clr_v1_idle", v1, 0);

        // write then read, latency 1 vs 2
        write = 1'b1; address = 4'd3; data = 20'h12345;
        step;
        write = 1'b0; load = 1'b1;
        step;
        load = 1'b0;
        check("wr_rd1", {v1, q1}, {1'b1, 20'h12345});
        check("wr_rd3", {v3, q3}, {1'b1, 20'h12345});
        check("wr_rd2_wait", {v2, q2}, {1'b0, INIT});
        step;
        check("wr_rd2", {v2, q2}, {1'b1, 20'h12345});
        check("wr_rd1_hold", {v1, q1}, {1'b0, 20'h12345});

        // read-first on same-cycle write and load
        write = 1'b1; address = 4'd7; data = 20'h00011;
        step;
        load = 1'b1; data = 20'h00055;
        step;
        write = 1'b0;
        check("rf_old1", {v1, q1}, {1'b1, 20'h00011});
        check("rf_old3", {v3, q3}, {1'b1, 20'h00011});
        step;
        load = 1'b0;
        check("rf_new1", {v1, q1}, {1'b1, 20'h00055});
        check("rf_old2", {v2, q2}, {1'b1, 20'h00011});
        step;
        check("rf_new2", {v2, q2}, {1'b1, 20'h00055});

        // out-of-range access on the 12-word instance
        write = 1'b1; address = 4'd13; data = 20'hFFFFF;
        step;
        write = 1'b0; load = 1'b1;
        step;
        load = 1'b0;
        check("oor_rd3", {v3, q3}, {1'b1, 20'h0});
        check("oor_rd1", {v1, q1}, {1'b1, 20'hFFFFF});
        for (int i = 0; i < 12; i++) begin
            load = 1'b1; address = AW'(i);
            step;
            exp_w = (i == 3) ? 20'h12345 : (i == 7) ? 20'h00055 : INIT;
            check("oor_keep3", {v3, q3}, {1'b1, exp_w});
        end
        load = 1'b0;
        step;

`ifdef RAM_SP_CTRL_PARITY_EN
        write = 1'b1; inject_err = 1'b1; address = 4'd5; data = 20'h00001;
        step;
        inject_err = 1'b0; address = 4'd6;
        step;
        write = 1'b0; load = 1'b1; address = 4'd5;
        step;
        check("perr_inj1", {v1, pe1, q1}, {1'b1, 1'b1, 20'h00001});
        address = 4'd6;
        step;
        check("perr_ok1", {v1, pe1}, {1'b1, 1'b0});
        check("perr_inj2", {v2, pe2}, {1'b1, 1'b1});
        address = 4'd13;
        step;
        load = 1'b0;
        check("perr_ok2", {v2, pe2}, {1'b1, 1'b0});
        check("perr_oor3", {v3, pe3, q3}, {1'b1, 1'b0, 20'h0});
        step;
        check("perr_pulse1", {v1, pe1}, {1'b0, 1'b0});
`endif

        // reset flushes an in-flight read
        load = 1'b1; address = 4'd3;
        step;
        load = 1'b0; rst = 1'b1;
        step;
        check("flush_rd2", {v2, q2}, 32'h0);
        check("flush_busy1", b1, 1);

        // accesses while busy, then reset at clear cycle 5
        rst = 1'b0;
        write = 1'b1; load = 1'b1; address = 4'd0; data = 20'h77777;
        nv = 0;
        for (int c = 0; c < 5; c++) begin
            nv += int'(v1) + int'(v2) + int'(v3);
            step;
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        n1 = 0; n2 = 0; n3 = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 11) begin
                write = 1'b0; load = 1'b0;
            end
            n1 += int'(b1); n2 += int'(b2); n3 += int'(b3);
            nv += int'(v1) + int'(v2) + int'(v3);
            step;
        end
        check("restart_cycles1", n1, 16);
        check("restart_cycles2", n2, 16);
        check("restart_cycles3", n3, 12);
        check("busy_no_valid", nv, 0);

        load = 1'b1; address = 4'd0;
        step;
        load = 1'b0;
        check("busy_no_wr1", {v1, q1}, {1'b1, INIT});
        check("busy_no_wr3", {v3, q3}, {1'b1, INIT});
        step;
        check("busy_no_wr2", {v2, q2}, {1'b1, INIT});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
